// File: rtl/multibit_fifo_sync_pkg.sv
// Shared types and gray/binary helpers for the 2-entry gray-pointer FIFO synchronizer.
package multibit_fifo_sync_pkg;

   localparam int FIFO_DEPTH = 2;

   typedef logic [1:0] ptr_gray_t;

   function automatic logic [1:0] gray2bin(input ptr_gray_t g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   function automatic ptr_gray_t bin2gray(input logic [1:0] b);
      return {b[1], b[1] ^ b[0]};
   endfunction

endpackage

// File: rtl/cdc_sync_bit_areset.sv
// Single-bit synchronizer chain with asynchronous active-high reset.
module cdc_sync_bit_areset #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/multibit_fifo_sync_wr.sv
// Write-side half of the 2-entry gray-pointer FIFO synchronizer: stores words,
// publishes the register file and gray write pointer, syncs back the read pointer.
module multibit_fifo_sync_wr
   import multibit_fifo_sync_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    s_valid,
   input  logic [DATA_WIDTH-1:0]   s_data,
   output logic                    s_ready,
   output logic [2*DATA_WIDTH-1:0] entry_data,
   output logic [1:0]              wr_ptr_gray,
   input  logic [1:0]              rd_ptr_gray,
   output logic [1:0]              level
);

   ptr_gray_t                                wr_ptr_q;
   ptr_gray_t                                wr_ptr_d;
   logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]    entry_q;
   logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0]    entry_d;
   ptr_gray_t                                rptr_sync_s;
   logic [1:0]                               wbin_s;
   logic [1:0]                               rbin_s;
   logic                                     full_s;
   logic                                     push_s;

   for (genvar i = 0; i < 2; i++) begin : g_rptr_sync
      cdc_sync_bit_areset #(
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk   (clk),
         .reset (reset),
         .d_i   (rd_ptr_gray[i]),
         .q_o   (rptr_sync_s[i])
      );
   end

   assign wbin_s  = gray2bin(wr_ptr_q);
   assign rbin_s  = gray2bin(rptr_sync_s);
   // Full when the pointers differ by exactly the depth: both gray bits inverted.
   assign full_s  = (wr_ptr_q == ~rptr_sync_s);
   assign s_ready = !reset && !full_s;
   assign push_s  = s_valid && s_ready;

   // Next-state: write the addressed entry and take one gray step on a transfer.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      entry_d  = entry_q;
      if (push_s) begin
         entry_d[wbin_s[0]] = s_data;
         wr_ptr_d           = bin2gray(wbin_s + 2'd1);
      end else begin
         entry_d  = entry_q;
         wr_ptr_d = wr_ptr_q;
      end
   end

   // Pointer and register-file state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= 2'b00;
         entry_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         entry_q  <= entry_d;
      end
   end

   assign wr_ptr_gray = wr_ptr_q;
   assign entry_data  = entry_q;
   assign level       = wbin_s - rbin_s;

endmodule

// File: tb/tb_multibit_fifo_sync_wr.sv
// Directed self-checking bench for multibit_fifo_sync_wr (SYNC_STAGES=2 and 3 instances).
module tb_multibit_fifo_sync_wr;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic [63:0] entry_data;
   logic [1:0]  wr_ptr_gray;
   logic [1:0]  rd_ptr_gray;
   logic [1:0]  level;

   logic        s_valid3;
   logic [31:0] s_data3;
   logic        s_ready3;
   logic [63:0] entry_data3;
   logic [1:0]  wr_ptr_gray3;
   logic [1:0]  rd_ptr_gray3;
   logic [1:0]  level3;

   int errors = 0;
   int checks = 0;
   logic       mon_en = 1'b0;
   logic [1:0] mon_prev = 2'b00;

   always #5 clk = ~clk;

   multibit_fifo_sync_wr #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .entry_data(entry_data), .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray), .level(level)
   );

   multibit_fifo_sync_wr #(.DATA_WIDTH(32), .SYNC_STAGES(3)) dut3 (
      .clk(clk), .reset(reset), .s_valid(s_valid3), .s_data(s_data3), .s_ready(s_ready3),
      .entry_data(entry_data3), .wr_ptr_gray(wr_ptr_gray3), .rd_ptr_gray(rd_ptr_gray3), .level(level3)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] b2g(input logic [1:0] b);
      return {b[1], b[1] ^ b[0]};
   endfunction

   // Gray one-bit-change and level-range monitor, active during the streaming phase.
   always @(posedge clk) begin
      #2;
      if (mon_en) begin
         if (wr_ptr_gray !== mon_prev)
            chk("gray_1bit", 64'($countones(wr_ptr_gray ^ mon_prev)), 64'd1);
         chk("level_le2", 64'(level <= 2'd2), 64'd1);
      end
      mon_prev = wr_ptr_gray;
   end

   initial begin
      logic [1:0]  mwbin;
      logic [1:0]  mrbin;
      logic [1:0]  hist1;
      logic [1:0]  hist2;
      logic        acc;
      int          k;
      int          cyc;
      logic [31:0] words [8];

      reset        = 1'b0;
      s_valid      = 1'b0;
      s_data       = 32'h0;
      rd_ptr_gray  = 2'b00;
      s_valid3     = 1'b0;
      s_data3      = 32'h0;
      rd_ptr_gray3 = 2'b00;
      #1 reset = 1'b1;
      #1;
      chk("rst_ready", 64'(s_ready), 64'd0);
      chk("rst_wptr", 64'(wr_ptr_gray), 64'd0);
      chk("rst_entry", entry_data, 64'd0);
      chk("rst_level", 64'(level), 64'd0);
      step();
      step();
      reset = 1'b0;
      #1;
      chk("rel_ready", 64'(s_ready), 64'd1);

      // Scenario 1: fill both entries
      s_valid = 1'b1;
      s_data  = 32'hA5A5A5A5;
      step();
      chk("s1_wptr0", 64'(wr_ptr_gray), 64'd1);
      chk("s1_level0", 64'(level), 64'd1);
      chk("s1_ready0", 64'(s_ready), 64'd1);
      s_data = 32'h5A5A5A5A;
      step();
      s_valid = 1'b0;
      chk("s1_wptr1", 64'(wr_ptr_gray), 64'd3);
      chk("s1_entry", entry_data, 64'h5A5A5A5A_A5A5A5A5);
      chk("s1_level1", 64'(level), 64'd2);
      chk("s1_full", 64'(s_ready), 64'd0);

      // Scenario 2: free a slot through the 2-stage sync
      rd_ptr_gray = 2'b01;
      step();
      chk("s2_edge1", 64'(s_ready), 64'd0);
      step();
      chk("s2_edge2", 64'(s_ready), 64'd1);
      chk("s2_level", 64'(level), 64'd1);
      s_valid = 1'b1;
      s_data  = 32'h12345678;
      step();
      chk("s2_wptr", 64'(wr_ptr_gray), 64'd2);
      chk("s2_entry", entry_data, 64'h5A5A5A5A_12345678);
      chk("s2_full", 64'(s_ready), 64'd0);

      // Scenario 3: s_valid held while full
      s_data = 32'hDEADBEEF;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("s3_entry", entry_data, 64'h5A5A5A5A_12345678);
         chk("s3_wptr", 64'(wr_ptr_gray), 64'd2);
      end
      s_valid = 1'b0;

      // Scenario 4: stream 8 words, read pointer trailing two cycles behind
      for (int i = 0; i < 8; i++) words[i] = 32'h1000_0000 + 32'(i);
      mwbin  = 2'd3;
      mrbin  = 2'd1;
      hist1  = 2'd3;
      hist2  = 2'd3;
      k      = 0;
      cyc    = 0;
      mon_en = 1'b1;
      s_valid = 1'b1;
      s_data  = words[0];
      while (k < 8 && cyc < 80) begin
         acc = s_valid && s_ready;
         step();
         cyc++;
         if (acc) begin
            mwbin = mwbin + 2'd1;
            k++;
         end
         if (mrbin != hist2) mrbin = mrbin + 2'd1;
         hist2       = hist1;
         hist1       = mwbin;
         rd_ptr_gray = b2g(mrbin);
         chk("s4_wptr", 64'(wr_ptr_gray), 64'(b2g(mwbin)));
         if (k < 8) s_data = words[k];
         else s_valid = 1'b0;
      end
      s_valid = 1'b0;
      chk("s4_done", 64'(k), 64'd8);
      chk("s4_wptr_end", 64'(wr_ptr_gray), 64'd2);
      chk("s4_entry", entry_data, {words[6], words[7]});
      rd_ptr_gray = 2'b11;
      step();
      step();
      step();
      mon_en = 1'b0;
      chk("s4_level1", 64'(level), 64'd1);

      // Scenario 5: asynchronous reset mid-cycle
      @(negedge clk);
      reset       = 1'b1;
      rd_ptr_gray = 2'b00;
      #1;
      chk("s5_ready", 64'(s_ready), 64'd0);
      chk("s5_wptr", 64'(wr_ptr_gray), 64'd0);
      chk("s5_entry", entry_data, 64'd0);
      chk("s5_level", 64'(level), 64'd0);
      #1;
      reset   = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'hCAFEF00D;
      #1;
      chk("s5_rel_ready", 64'(s_ready), 64'd1);
      step();
      s_valid = 1'b0;
      chk("s5_entry0", entry_data, 64'h00000000_CAFEF00D);
      chk("s5_wptr1", 64'(wr_ptr_gray), 64'd1);

      // Scenario 6: SYNC_STAGES=3 instance
      chk("s6_rst_wptr", 64'(wr_ptr_gray3), 64'd0);
      s_valid3 = 1'b1;
      s_data3  = 32'h11111111;
      step();
      s_data3 = 32'h22222222;
      step();
      s_valid3 = 1'b0;
      chk("s6_wptr", 64'(wr_ptr_gray3), 64'd3);
      chk("s6_entry", entry_data3, 64'h22222222_11111111);
      chk("s6_full", 64'(s_ready3), 64'd0);
      rd_ptr_gray3 = 2'b01;
      step();
      chk("s6_edge1", 64'(s_ready3), 64'd0);
      step();
      chk("s6_edge2", 64'(s_ready3), 64'd0);
      step();
      chk("s6_edge3", 64'(s_ready3), 64'd1);
      chk("s6_level", 64'(level3), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
